uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: size, default 32, number of data bits per frame.
REQ-002 CLK_Baudin  input  1  bit clock; one line sample per rising edge, one bit period per cycle.
REQ-003 RstRx  input  1  reset; asynchronous and active-high.
REQ-004 RxSerialData  input  1  serial line; idles high.
REQ-005 DataOut  output  size  last frame received without error.
REQ-006 DoneRx  output  1  one-cycle pulse; DataOut updated and valid.
REQ-007 Flag_out  output  1  parity-error NACK to the transmitter's Flag_in; valid in the parity-bit cycle.
REQ-008 FrameErr  output  1  one-cycle pulse; stop bit sampled low.

Function
REQ-009 The frame SHALL be: start (0), size data bits LSB first, one even-parity bit, stop (1).
REQ-010 The parity bit SHALL equal the XOR of all size data bits.
REQ-011 The FSM SHALL have exactly four states: IDLE, DATA, PARITY, STOP.
REQ-012 IDLE: RxSerialData==0 at an edge SHALL go to DATA with bit counter=0; a 1 SHALL stay in IDLE.
REQ-013 DATA: each edge SHALL shift the line value in at the MSB (shift right, LSB first) and increment the counter.
REQ-014 DATA SHALL go to PARITY on the edge that samples data bit size-1.
REQ-015 Flag_out SHALL be combinational: Flag_out = (state==PARITY) & (RxSerialData XOR accumulated parity); this ensures it is visible in the same cycle the transmitter samples Flag_in.
REQ-016 PARITY SHALL register the parity-error result and go to STOP on the next edge.
REQ-017 STOP, no parity error, line==1: DataOut<=shift register; DoneRx=1 for one cycle; go to IDLE.
REQ-018 STOP, no parity error, line==0: DataOut SHALL be unchanged; FrameErr=1 for one cycle; go to IDLE.
REQ-019 STOP, parity error: no DoneRx, no FrameErr, DataOut unchanged; go to IDLE and await a fresh start bit.
REQ-020 Latency: with the start bit sampled at edge 0, DoneRx SHALL be high for the cycle after edge size+2 (edge 34 for size=32).
REQ-021 The bit counter SHALL be $clog2(size)+1 bits wide and SHALL NOT wrap within a frame.
REQ-022 DoneRx and FrameErr SHALL never be high together; each SHALL be high at most one cycle per frame.
REQ-023 A line glitch to 0 during IDLE SHALL be treated as a start bit; no false-start filtering.
REQ-024 Unused state encodings SHALL go to IDLE on the next edge.

Reset
REQ-025 RstRx high SHALL force state=IDLE, counter=0, shift=0, DataOut=0, DoneRx=0, FrameErr=0 and the parity accumulator cleared; Flag_out is then 0.
REQ-026 Reset mid-frame SHALL discard the partial frame.
REQ-027 After reset, reception SHALL restart only on a new start bit.

Structure
REQ-028 A shared package SHALL hold the state encodings (IDLE=2'b00, DATA=2'b01, PARITY=2'b10, STOP=2'b11) and the default size=32.
REQ-029 Parity accumulation SHALL reuse the existing paritygen sub-module, connected as follows:
  - ip=RxSerialData
  - clk=CLK_Baudin
  - rst_p held high while in IDLE or under reset
REQ-030 The RTL SHALL consist of a single FSM process plus that one instance; it contains no FIFO.

Verification
REQ-031 Reset then frame 0xA5A5_0F0F, parity 0, stop 1 -> DoneRx one cycle after edge 34; DataOut=0xA5A5_0F0F; Flag_out=0 throughout.
REQ-032 Frame 0x0000_0001 with parity bit sent as 0 (wrong) -> Flag_out=1 in the parity cycle; no DoneRx; DataOut retains its previous value.
REQ-033 Frame 0xFFFF_FFFF, parity 0, stop bit 0 -> FrameErr pulse one cycle; DoneRx=0; DataOut unchanged.
REQ-034 Assert RstRx after data bit 10 of frame 0x1234_5678 -> all outputs 0; the next complete frame 0xDEAD_BEEF is received correctly.
REQ-035 Back-to-back frames 0x1 then 0x8000_0000 with a stop bit, then an immediate start bit -> two DoneRx pulses 35 cycles apart with correct data.
REQ-036 Loopback with the transmitter sending 0xCAFE_F00D -> transmitter DoneTx and receiver DoneRx both asserted; DataOut equals DataIn.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the serial receiver: FSM state encoding, default
// frame width and the bit-counter width helper.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

   localparam int SIZE_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      DATA   = 2'b01,
      PARITY = 2'b10,
      STOP   = 2'b11
   } state_t;

   // One spare bit so the counter reaches size without wrapping.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Serial line plus receiver result signals.
//   RxSerialData : serial line into the receiver (idles high)
//   DataOut      : last frame received without error
//   DoneRx       : one-cycle pulse, DataOut just updated
//   Flag_out     : parity-error NACK back to the transmitter (parity cycle)
//   FrameErr     : one-cycle pulse, stop bit sampled low
// master = line driver / result consumer, slave = receiver.
// -----------------------------------------------------------------------------
interface uart_rx_if import uart_rx_pkg::*; #(
   parameter int size = SIZE_DEFAULT
) ();

   logic            RxSerialData;
   logic [size-1:0] DataOut;
   logic            DoneRx;
   logic            Flag_out;
   logic            FrameErr;

   modport master (
      output RxSerialData,
      input  DataOut,
      input  DoneRx,
      input  Flag_out,
      input  FrameErr
   );

   modport slave (
      input  RxSerialData,
      output DataOut,
      output DoneRx,
      output Flag_out,
      output FrameErr
   );

endinterface

// File: rtl/uart_rx_paritygen.sv
// -----------------------------------------------------------------------------
// uart_rx_paritygen
// Running XOR of the serial input, one bit per clock.
//   clk   : bit clock
//   rst_p : synchronous clear, held high while no frame is being accumulated
//   ip    : serial bit to fold in
//   op    : accumulated parity of the bits seen since rst_p dropped
// -----------------------------------------------------------------------------
module uart_rx_paritygen (
   input  logic clk,
   input  logic rst_p,
   input  logic ip,
   output logic op
);

   logic par_q;
   logic par_d;

   always_comb begin
      par_d = rst_p ? 1'b0 : (par_q ^ ip);
   end

   always_ff @(posedge clk) begin
      par_q <= par_d;
   end

   assign op = par_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Frame receiver sampling one line bit per bit-clock edge.
// Frame: start(0), size data bits LSB first, even-parity bit, stop(1).
//   CLK_Baudin : bit clock, one sample per rising edge
//   RstRx      : asynchronous active-high reset
//   rx         : uart_rx_if.slave (line in, DataOut/DoneRx/Flag_out/FrameErr)
// -----------------------------------------------------------------------------
module uart_rx import uart_rx_pkg::*; #(
   parameter int size = SIZE_DEFAULT
) (
   input  logic      CLK_Baudin,
   input  logic      RstRx,
   uart_rx_if.slave  rx
);

   localparam int               CNT_W    = cnt_width(size);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(size - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [size-1:0]   shift_q, shift_d;
   logic [size-1:0]   data_q, data_d;
   logic              done_q, done_d;
   logic              ferr_q, ferr_d;
   logic              perr_q, perr_d;

   logic              line;
   logic              par_acc;
   logic              par_rst;
   logic              par_mismatch;

   assign line = rx.RxSerialData;

   // Accumulator is held clear in IDLE so it starts fresh with data bit 0.
   assign par_rst = RstRx | (state_q == IDLE);

   uart_rx_paritygen u_paritygen (
      .clk   (CLK_Baudin),
      .rst_p (par_rst),
      .ip    (line),
      .op    (par_acc)
   );

   assign par_mismatch = line ^ par_acc;

   // Combinational so the transmitter sees the NACK within the parity cycle.
   assign rx.Flag_out = (state_q == PARITY) & par_mismatch;
   assign rx.DataOut  = data_q;
   assign rx.DoneRx   = done_q;
   assign rx.FrameErr = ferr_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      data_d  = data_q;
      perr_d  = perr_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // Any low sample is taken as a start bit.
            if (!line) begin
               state_d = DATA;
               cnt_d   = '0;
            end
         end
         DATA: begin
            // LSB arrives first, so shifting right leaves it at bit 0.
            shift_d = {line, shift_q[size-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = PARITY;
            end
         end
         PARITY: begin
            perr_d  = par_mismatch;
            state_d = STOP;
         end
         STOP: begin
            if (!perr_q) begin
               if (line) begin
                  data_d = shift_q;
                  done_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_Baudin or posedge RstRx) begin
      if (RstRx) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Builds a line waveform out of whole frames, derives from each frame the
// outcome it must produce and when, then replays the waveform one bit per
// clock and compares every receiver output on every cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx;
   import uart_rx_pkg::*;

   localparam int SIZE = 32;

   logic clk;
   logic rst;

   uart_rx_if #(.size(SIZE)) bus ();

   uart_rx #(.size(SIZE)) dut (
      .CLK_Baudin (clk),
      .RstRx      (rst),
      .rx         (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus stream: one entry per bit period.
   logic line_s[$];
   logic rst_s[$];

   // Scheduled outcomes (stream indices at which they are observed).
   int              done_at[$];
   logic [SIZE-1:0] done_val[$];
   int              ferr_at[$];
   int              flag_at[$];

   logic            exp_done[];
   logic            exp_ferr[];
   logic            exp_flag[];
   logic [SIZE-1:0] exp_data[];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic void push(input logic b, input logic r);
      line_s.push_back(b);
      rst_s.push_back(r);
   endfunction

   function automatic void idle(input int n);
      for (int i = 0; i < n; i++) push(1'b1, 1'b0);
   endfunction

   function automatic void reset_cycles(input int n);
      for (int i = 0; i < n; i++) push(1'b1, 1'b1);
   endfunction

   // A frame whose start bit is sampled at stream index s: Flag_out is seen
   // while the parity bit is on the line (s+SIZE+1); the result pulse is seen
   // in the period after the stop-bit edge (s+SIZE+3).
   function automatic void frame(input logic [SIZE-1:0] d, input logic pb, input logic sb);
      int s;
      s = line_s.size();
      push(1'b0, 1'b0);
      for (int i = 0; i < SIZE; i++) push(d[i], 1'b0);
      push(pb, 1'b0);
      push(sb, 1'b0);
      if (pb != (^d)) begin
         flag_at.push_back(s + SIZE + 1);
      end else if (sb) begin
         done_at.push_back(s + SIZE + 3);
         done_val.push_back(d);
      end else begin
         ferr_at.push_back(s + SIZE + 3);
      end
   endfunction

   // Start bit plus the first nbits data bits, with no outcome scheduled.
   function automatic void partial_frame(input logic [SIZE-1:0] d, input int nbits);
      push(1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) push(d[i], 1'b0);
   endfunction

   function automatic logic [SIZE-1:0] good_par_frame(input logic [SIZE-1:0] d);
      frame(d, ^d, 1'b1);
      return d;
   endfunction

   initial begin
      logic [SIZE-1:0] d;
      logic [SIZE-1:0] cur;
      logic            pb;
      logic            sb;
      int              n;

      rst = 1'b1;
      bus.RxSerialData = 1'b1;

      reset_cycles(3);
      idle(2);
      void'(good_par_frame(32'hA5A5_0F0F));
      idle(3);
      frame(32'h0000_0001, 1'b0, 1'b1);          // wrong parity
      idle(2);
      frame(32'hFFFF_FFFF, 1'b0, 1'b0);          // stop bit low
      idle(2);
      void'(good_par_frame(32'h0000_0001));      // back-to-back run
      void'(good_par_frame(32'h8000_0000));
      void'(good_par_frame(32'hCAFE_F00D));
      idle(2);
      partial_frame(32'h1234_5678, 11);          // reset after data bit 10
      reset_cycles(2);
      idle(2);
      void'(good_par_frame(32'hDEAD_BEEF));
      idle(1);
      for (int f = 0; f < 30; f++) begin
         d  = $urandom;
         pb = (^d) ^ ($urandom_range(0, 6) == 0);
         sb = ($urandom_range(0, 6) != 0);
         frame(d, pb, sb);
         idle($urandom_range(0, 3));
      end
      idle(4);

      n = line_s.size();
      exp_done = new[n];
      exp_ferr = new[n];
      exp_flag = new[n];
      exp_data = new[n];
      for (int k = 0; k < n; k++) begin
         exp_done[k] = 1'b0;
         exp_ferr[k] = 1'b0;
         exp_flag[k] = 1'b0;
      end
      foreach (flag_at[i]) if (flag_at[i] < n) exp_flag[flag_at[i]] = 1'b1;
      foreach (ferr_at[i]) if (ferr_at[i] < n) exp_ferr[ferr_at[i]] = 1'b1;

      // DataOut holds the most recent good frame; reset clears it.
      cur = '0;
      for (int k = 0; k < n; k++) begin
         if (rst_s[k]) cur = '0;
         foreach (done_at[i]) begin
            if (done_at[i] == k) begin
               exp_done[k] = 1'b1;
               cur = done_val[i];
            end
         end
         exp_data[k] = cur;
      end

      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         bus.RxSerialData = line_s[k];
         rst = rst_s[k];
         #1;
         cyc = k;
         chk("DoneRx",   bus.DoneRx,   exp_done[k]);
         chk("FrameErr", bus.FrameErr, exp_ferr[k]);
         chk("Flag_out", bus.Flag_out, exp_flag[k]);
         chk("DataOut",  bus.DataOut,  exp_data[k]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
